// File: rtl/demux32_1_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake.
// One producer stream is steered by in_sel into one of four one-entry
// holding registers. in_ready looks only at the selected channel, and the
// outputs come straight from registers, so out_ready never reaches
// out_valid/out_data combinationally.
module demux32_1_4_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] xfer_count
);

  logic [3:0]       out_valid_r;
  logic [WIDTH-1:0] data_r [4];
  logic [CNT_W-1:0] xfer_count_r;

  logic             sel_free_s;
  logic             in_ready_s;
  logic             acc_s;
  logic [3:0]       load_s;
  logic [3:0]       drain_s;

  // Handshake decode: readiness of the selected channel, accept strobe,
  // per-channel load and drain enables.
  always_comb begin
    sel_free_s = 1'b0;
    in_ready_s = 1'b0;
    acc_s      = 1'b0;
    load_s     = 4'b0000;
    drain_s    = out_valid_r & out_ready;
    // A channel can take a word if empty or emptying on this same edge.
    sel_free_s = ~out_valid_r[in_sel] | out_ready[in_sel];
    in_ready_s = ~flush & sel_free_s;
    acc_s      = in_valid & in_ready_s;
    if (acc_s) begin
      case (in_sel)
        2'd0:    load_s = 4'b0001;
        2'd1:    load_s = 4'b0010;
        2'd2:    load_s = 4'b0100;
        2'd3:    load_s = 4'b1000;
        default: load_s = 4'b0000;
      endcase
    end else begin
      load_s = 4'b0000;
    end
  end

  // Per-channel FULL bits: load sets, drain clears, load wins over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 4'b0000;
    end else if (flush) begin
      out_valid_r <= 4'b0000;
    end else begin
      out_valid_r <= (out_valid_r & ~drain_s) | load_s;
    end
  end

  // Holding registers: capture in_data into the channel being loaded.
  // Contents survive flush; only out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          data_r[k] <= in_data;
        end
      end
    end
  end

  // Accepted-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_r <= {CNT_W{1'b0}};
    end else if (acc_s) begin
      xfer_count_r <= xfer_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data0  = data_r[0];
  assign out_data1  = data_r[1];
  assign out_data2  = data_r[2];
  assign out_data3  = data_r[3];
  assign xfer_count = xfer_count_r;

endmodule
